// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller side is "master": it reads decode/status and drives every enable and mux.
interface multicycle_ctrl_if #(
   parameter int INSTR_WIDTH    = 32,
   parameter int ALU_CTRL_WIDTH = 3
);
   logic [INSTR_WIDTH-1:0]    instr;
   logic                      Zero;
   logic                      mem_ready;
   logic                      PCWrite;
   logic                      IRWrite;
   logic                      AdrSrc;
   logic                      MemWrite;
   logic                      RegWrite;
   logic [1:0]                ResultSrc;
   logic [1:0]                ALUSrcA;
   logic [1:0]                ALUSrcB;
   logic [ALU_CTRL_WIDTH-1:0] ALUControl;
   logic [1:0]                ImmSrc;
   logic                      instr_done;
   logic                      illegal;

   modport master (
      input  instr, Zero, mem_ready,
      output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
   );

   modport slave (
      output instr, Zero, mem_ready,
      input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback
// sequencing over a shared ALU and unified memory, stalling on mem_ready.
module multicycle_ctrl #(
   parameter int INSTR_WIDTH    = 32,
   parameter int ALU_CTRL_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_ctrl_if.master    bus
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BRAN  = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b000);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b001);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b010);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b011);
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b101);

   state_t r_state;
   state_t w_next;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_funct7b5;

   assign w_opcode   = bus.instr[6:0];
   assign w_funct3   = bus.instr[14:12];
   assign w_funct7b5 = bus.instr[30];

   // Only R-type honours funct7b5; addi with a negative immediate must stay an add.
   function automatic logic [ALU_CTRL_WIDTH-1:0] alu_decode(
      input logic [2:0] f3, input logic is_rtype, input logic f7b5);
      case (f3)
         3'b000:  alu_decode = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_decode = ALU_SLT;
         3'b110:  alu_decode = ALU_OR;
         3'b111:  alu_decode = ALU_AND;
         default: alu_decode = ALU_ADD;
      endcase
   endfunction

   function automatic logic [1:0] imm_decode(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_ITYPE: imm_decode = 2'b00;
         OP_BRAN:           imm_decode = 2'b01;
         OP_STORE:          imm_decode = 2'b10;
         OP_JAL:            imm_decode = 2'b11;
         default:           imm_decode = 2'b00;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:          w_next = S_EXECR;
               OP_ITYPE:          w_next = S_EXECI;
               OP_BRAN:           w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               default:           w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.mem_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready) w_next = S_FETCH;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   logic                      w_pcwrite, w_irwrite, w_adrsrc, w_memwrite, w_regwrite;
   logic [1:0]                w_resultsrc, w_srca, w_srcb, w_immsrc;
   logic [ALU_CTRL_WIDTH-1:0] w_aluctrl;
   logic                      w_done, w_illegal;

   always_comb begin
      w_pcwrite   = 1'b0;
      w_irwrite   = 1'b0;
      w_adrsrc    = 1'b0;
      w_memwrite  = 1'b0;
      w_regwrite  = 1'b0;
      w_resultsrc = 2'b00;
      w_srca      = 2'b00;
      w_srcb      = 2'b00;
      w_aluctrl   = ALU_ADD;
      w_immsrc    = imm_decode(w_opcode);
      w_done      = 1'b0;
      w_illegal   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_srcb      = 2'b10;
            w_resultsrc = 2'b10;
            w_irwrite   = bus.mem_ready;
            w_pcwrite   = bus.mem_ready;
         end
         S_DECODE: begin
            w_srca = 2'b01;
            w_srcb = 2'b01;
            case (w_opcode)
               OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRAN, OP_JAL: ;
               default: begin
                  w_illegal = 1'b1;
                  w_done    = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            w_srca = 2'b10;
            w_srcb = 2'b01;
         end
         S_MEMREAD: w_adrsrc = 1'b1;
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
            w_done      = 1'b1;
         end
         S_MEMWRITE: begin
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
            w_done     = bus.mem_ready;
         end
         S_EXECR: begin
            w_srca    = 2'b10;
            w_aluctrl = alu_decode(w_funct3, 1'b1, w_funct7b5);
         end
         S_EXECI: begin
            w_srca    = 2'b10;
            w_srcb    = 2'b01;
            w_aluctrl = alu_decode(w_funct3, 1'b0, w_funct7b5);
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            w_done     = 1'b1;
         end
         S_BRANCH: begin
            w_srca    = 2'b10;
            w_aluctrl = ALU_SUB;
            w_done    = 1'b1;
            if (w_funct3 == 3'b000)      w_pcwrite = bus.Zero;
            else if (w_funct3 == 3'b001) w_pcwrite = ~bus.Zero;
         end
         S_JAL: begin
            w_srca    = 2'b01;
            w_srcb    = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: ;
      endcase
      // Reset is asynchronous, so the datapath must see quiet controls without waiting for a clock.
      if (rst) begin
         w_pcwrite   = 1'b0;
         w_irwrite   = 1'b0;
         w_adrsrc    = 1'b0;
         w_memwrite  = 1'b0;
         w_regwrite  = 1'b0;
         w_resultsrc = 2'b00;
         w_srca      = 2'b00;
         w_srcb      = 2'b00;
         w_aluctrl   = ALU_ADD;
         w_immsrc    = 2'b00;
         w_done      = 1'b0;
         w_illegal   = 1'b0;
      end
   end

   assign bus.PCWrite    = w_pcwrite;
   assign bus.IRWrite    = w_irwrite;
   assign bus.AdrSrc     = w_adrsrc;
   assign bus.MemWrite   = w_memwrite;
   assign bus.RegWrite   = w_regwrite;
   assign bus.ResultSrc  = w_resultsrc;
   assign bus.ALUSrcA    = w_srca;
   assign bus.ALUSrcB    = w_srcb;
   assign bus.ALUControl = w_aluctrl;
   assign bus.ImmSrc     = w_immsrc;
   assign bus.instr_done = w_done;
   assign bus.illegal    = w_illegal;

   // ALU_AND and ALU_OR are referenced so every encoding is named in one place.
   logic w_enc_ok;
   assign w_enc_ok = (ALU_AND != ALU_OR);

   always_comb begin
      assert (rst || w_enc_ok);
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes a hand-computed control vector
// per cycle, a monitor pops and compares it at the falling edge.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.INSTR_WIDTH(32), .ALU_CTRL_WIDTH(3)) bus ();

   multicycle_ctrl #(.INSTR_WIDTH(32), .ALU_CTRL_WIDTH(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string      nm;
      logic [17:0] e;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Field order: PCWrite IRWrite AdrSrc MemWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc done illegal
   function automatic logic [17:0] mk(
      input logic pcw, input logic irw, input logic adr, input logic mw, input logic rw,
      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sbb,
      input logic [2:0] alu, input logic [1:0] imm, input logic done, input logic ill);
      return {pcw, irw, adr, mw, rw, rs, sa, sbb, alu, imm, done, ill};
   endfunction

   function automatic logic [17:0] observe();
      return {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite,
              bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
              bus.instr_done, bus.illegal};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t x;
            logic [17:0] got;
            x   = sb.pop_front();
            got = observe();
            n_tests++;
            if (got !== x.e) begin
               n_fail++;
               $display("FAIL %s got %b required %b", x.nm, got, x.e);
            end
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic mr, input logic z,
                       input logic [17:0] e);
      rst           = r;
      bus.mem_ready = mr;
      bus.Zero      = z;
      sb.push_back('{nm, e});
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_decode(input string nm, input logic [1:0] imm);
      step({nm, "_fetch"},  1'b0, 1'b1, 1'b0, mk(1,1,0,0,0,2'b10,2'b00,2'b10,3'b000,imm,0,0));
      step({nm, "_decode"}, 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,imm,0,0));
   endtask

   initial begin
      rst           = 1'b1;
      bus.instr     = 32'h0020A423;
      bus.mem_ready = 1'b1;
      bus.Zero      = 1'b0;

      step("reset0", 1'b1, 1'b1, 1'b0, 18'd0);
      step("reset1", 1'b1, 1'b1, 1'b0, 18'd0);

      // addi x1,x0,5 with one fetch stall
      bus.instr = 32'h00500093;
      step("addi_fetch_stall", 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
      fetch_decode("addi", 2'b00);
      step("addi_execi", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
      step("addi_aluwb", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

      // slti -> slt
      bus.instr = 32'h0020A093;
      fetch_decode("slti", 2'b00);
      step("slti_execi", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0,0));
      step("slti_aluwb", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

      // lw with three stall cycles in MEMREAD
      bus.instr = 32'h0040A103;
      fetch_decode("lw", 2'b00);
      step("lw_memadr", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
      for (int i = 0; i < 3; i++)
         step("lw_memread_stall", 1'b0, 1'b0, 1'b0, mk(0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
      step("lw_memread", 1'b0, 1'b1, 1'b0, mk(0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
      step("lw_memwb", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,1,0));

      // sw
      bus.instr = 32'h0020A423;
      fetch_decode("sw", 2'b10);
      step("sw_memadr", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b10,0,0));
      step("sw_memwrite", 1'b0, 1'b1, 1'b0, mk(0,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b10,1,0));

      // beq taken / not taken, bne taken
      bus.instr = 32'h00000463;
      fetch_decode("beq_z1", 2'b01);
      step("beq_z1_branch", 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b01,1,0));
      fetch_decode("beq_z0", 2'b01);
      step("beq_z0_branch", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b01,1,0));
      bus.instr = 32'h00001463;
      fetch_decode("bne_z0", 2'b01);
      step("bne_z0_branch", 1'b0, 1'b1, 1'b0, mk(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b01,1,0));

      // sub / add R-type
      bus.instr = 32'h402081B3;
      fetch_decode("sub", 2'b00);
      step("sub_execr", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0));
      step("sub_aluwb", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
      bus.instr = 32'h002081B3;
      fetch_decode("add", 2'b00);
      step("add_execr", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0,0));
      step("add_aluwb", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

      // jal
      bus.instr = 32'h010000EF;
      fetch_decode("jal", 2'b11);
      step("jal_jal", 1'b0, 1'b1, 1'b0, mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0));
      step("jal_aluwb", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b11,1,0));

      // illegal opcode
      bus.instr = 32'h0000007F;
      step("ill_fetch", 1'b0, 1'b1, 1'b0, mk(1,1,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
      step("ill_decode", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,1,1));

      // reset during a MEMWRITE stall, then a clean sw
      bus.instr = 32'h0020A423;
      fetch_decode("swr", 2'b10);
      step("swr_memadr", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b10,0,0));
      step("swr_memwrite_stall", 1'b0, 1'b0, 1'b0, mk(0,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b10,0,0));
      step("swr_rst_mid", 1'b1, 1'b0, 1'b0, 18'd0);
      step("swr_rst_hold", 1'b1, 1'b0, 1'b0, 18'd0);
      fetch_decode("swr_after", 2'b10);
      step("swr_after_memadr", 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b10,0,0));
      step("swr_after_memwrite", 1'b0, 1'b1, 1'b0, mk(0,0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b10,1,0));

      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified instruction/data memory. It drives the immediate-format select into the sign-extension unit and all datapath enables and muxes. It stalls on a memory ready handshake.

Parameters:
INSTR_WIDTH, 32, instruction width held in the instruction register
ALU_CTRL_WIDTH, 3, width of ALUControl

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
instr  in  INSTR_WIDTH  current instruction register contents; opcode [6:0], funct3 [14:12], funct7b5 [30]
Zero  in  1  ALU zero flag, valid in the BRANCH state
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  PC register enable
IRWrite  out  1  instruction register (and OldPC) enable
AdrSrc  out  1  memory address: 0=PC, 1=Result
MemWrite  out  1  memory write strobe
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=Data register, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1 register
ALUSrcB  out  2  00=WriteData register, 01=ImmExt, 10=constant 4
ALUControl  out  ALU_CTRL_WIDTH  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  sign-extend format: 00=I, 01=B, 10=S, 11=J
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- State register is reset asynchronously to FETCH. While rst=1, every output is 0.
- Outputs are combinational from the state, plus instr and Zero where noted. Unlisted outputs are 0. ImmSrc is decoded from the opcode in every state: 0000011/0010011 -> 00, 1100011 -> 01, 0100011 -> 10, 1101111 -> 11, others 00.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target into ALUOut). Next state by opcode:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode: illegal=1, instr_done=1, next state FETCH, no writes.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if opcode=0000011, otherwise MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1, then FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until mem_ready. In the mem_ready cycle it pulses instr_done and goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00. EXECUTEI: ALUSrcA=10, ALUSrcB=01. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1, then FETCH.
- ALU decode by funct3:
  - 000 -> add; sub only when opcode=0110011 and funct7b5=1
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - any other funct3 -> add
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=Zero when funct3=000 (beq), PCWrite=~Zero when funct3=001 (bne), 0 otherwise. Pulses instr_done, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Then goes to ALUWB, which writes the return address to rd.
- Latency with mem_ready tied high, in cycles from FETCH entry to instr_done inclusive: lw 5, sw 4, R/I-type 4, branch 3, jal 4, illegal 2. Each extra cycle of mem_ready=0 adds one cycle.
- instr changes only on IRWrite, so decode is stable from DECODE onward.
- Reset asserted in any state, including mid-stall: next cycle after release is FETCH, with no partial MemWrite or RegWrite.

Test Plan:
- Reset then release with mem_ready=1, instr=0x00500093 (addi): FETCH(IRWrite=1, PCWrite=1) -> DECODE -> EXECUTEI (ALUSrcB=01, ImmSrc=00) -> ALUWB (RegWrite=1, instr_done=1); 4 cycles.
- instr=0x0040A103 (lw) with mem_ready low for 3 cycles in MEMREAD: MEMREAD held 4 cycles with AdrSrc=1 and no RegWrite; then MEMWB with ResultSrc=01, RegWrite=1; total 8 cycles.
- instr=0x0020A423 (sw): MEMADR ImmSrc=10; MemWrite=1 exactly in MEMWRITE cycles; RegWrite never 1; instr_done after 4 cycles.
- instr=0x00000463 (beq) with Zero=1 -> PCWrite=1 in BRANCH. Repeat with Zero=0 -> PCWrite=0. Repeat with bne encoding 0x00001463 and Zero=0 -> PCWrite=1. ImmSrc=01 throughout.
- instr=0x402081B3 (sub) -> ALUControl=001 in EXECUTER. Repeat with 0x002081B3 (add) -> ALUControl=000. jal 0x010000EF -> ImmSrc=11, PCWrite=1 in JAL, then RegWrite in ALUWB.
- instr=0x0000007F (illegal) -> illegal and instr_done pulse in DECODE, no writes. Separately, assert rst during a MEMWRITE stall: MemWrite drops immediately and the FSM restarts in FETCH.
